regfile_multi: RTL and testbench
================================

Name: regfile_multi

Overview:
Parametrised two-write/two-read register file for the hlcpu datapath. Generalises data width and depth, and adds per-port write/read enables, registered reads with a valid flag, an optional hardwired zero register, and a sequential clear sweep that runs after reset or on request. Sits between decode (read selects) and writeback (write ports).

Parameters:
DATA_W, 16, width of each register in bits
ADDR_W, 4, select width; DEPTH = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register
RESET_VAL, 0, DATA_W-bit value written to every entry by the clear sweep

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset, synchronous, active-high
clear  input  1  one-cycle request to re-run the clear sweep
busy  output  1  high while the clear sweep is running
wr1_en  input  1  write port 1 enable
wr1_sel  input  ADDR_W  write port 1 address
wr1_data  input  DATA_W  write port 1 data
wr2_en  input  1  write port 2 enable
wr2_sel  input  ADDR_W  write port 2 address
wr2_data  input  DATA_W  write port 2 data
rd1_en  input  1  read port 1 request
rd1_sel  input  ADDR_W  read port 1 address
rd1_data  output  DATA_W  read port 1 data, registered
rd1_valid  output  1  read port 1 data valid, one cycle per request
rd2_en  input  1  read port 2 request
rd2_sel  input  ADDR_W  read port 2 address
rd2_data  output  DATA_W  read port 2 data, registered
rd2_valid  output  1  read port 2 data valid

Behaviour:
- Reset: synchronous, active-high. On any edge with rst=1: state<=SWEEP, ptr<=0, busy<=1, rd1/rd2_data<=0, rd1/rd2_valid<=0. Holding rst keeps ptr at 0. rst overrides clear and all port activity, including mid-sweep.
- FSM states: IDLE, SWEEP.
- SWEEP, each edge with rst=0: mem[ptr]<=RESET_VAL, ptr<=ptr+1. On the edge where ptr==DEPTH-1: state<=IDLE, busy<=0. busy is therefore high for exactly DEPTH edges after rst falls (16 for the defaults).
- SWEEP: write enables are ignored and the data is dropped. Read enables are ignored, rd*_valid stays 0, and rd*_data holds. clear is ignored.
- IDLE plus clear=1: state<=SWEEP, ptr<=0, busy<=1 on that edge. Port activity sampled on the same edge is still serviced as in IDLE.
- IDLE writes: on the edge, if wrN_en=1 then mem[wrN_sel]<=wrN_data. If both ports write the same address, wr2 wins.
- IDLE reads: 1-cycle latency.
  - rdN_en=1 at edge k: at edge k, rdN_data<=mem[rdN_sel] and rdN_valid<=1.
  - rdN_en=0: rdN_valid<=0 and rdN_data holds.
  - Back-to-back requests give valid on consecutive cycles.
- Read-during-write to the same address on the same edge: returns the old value (see Optional Feature).
- ZERO_REG=1: writes to address 0 are discarded, reads of address 0 return 0, and the sweep still visits entry 0.
- Selects are don't-care when the matching enable is 0. X on a disabled select must not corrupt state.
- Widths: ptr is ADDR_W bits. Comparison with DEPTH-1 is done at full width, with no wrap beyond the terminal count.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: a read whose address matches an enabled write on the same edge returns the write data, with wr2 data taking precedence if both ports match. The zero-register rule still wins. This applies only in IDLE.
- Undefined: such a read returns the pre-write contents of mem.

Test Plan:
- Reset sweep: rst high 2 cycles then low. busy=1 for exactly 16 edges then 0. A subsequent read of every address yields 0000 with valid=1 one cycle after each request.
- Dual write/read: wr1 sel=1 data=DEAD, wr2 sel=2 data=BEEF. Next cycle rd1 sel=1, rd2 sel=2. One edge later rd1_data=DEAD, rd2_data=BEEF, both valid=1. The following idle cycle gives valid=0 with data held.
- Write conflict and zero register: wr1 and wr2 both sel=5 with 1111 and 2222, plus a write of ABCD to sel=0. Reading 5 gives 2222 and reading 0 gives 0000. With ZERO_REG=0, reading 0 gives ABCD.
- Read-during-write: write sel=3 data=CAFE while reading sel=3 that previously held 0042. Without REGFILE_BYPASS_EN rd_data=0042; with it rd_data=CAFE. A later read gives CAFE in both builds.
- Clear mid-operation: load 1234 at sel=7, then pulse clear. busy is high 16 cycles, a write of 5555 to sel=8 during the sweep is dropped, and rd_valid stays 0 during the sweep. Afterwards sel=7 and sel=8 both read 0000.
- Reset mid-sweep: assert rst at sweep cycle 6. The sweep restarts from ptr=0 and busy stays high for a full 16 edges after rst falls.

Source files
------------

// File: rtl/regfile_multi.sv
// Parametrised two-write/two-read register file with registered reads and a sequential clear sweep.
// Optional build macro REGFILE_BYPASS_EN: same-edge write data is forwarded to matching reads.
module regfile_multi #(
   parameter int unsigned          DATA_W    = 16,
   parameter int unsigned          ADDR_W    = 4,
   parameter int unsigned          ZERO_REG  = 1,
   parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   output logic              busy,
   input  logic              wr1_en,
   input  logic [ADDR_W-1:0] wr1_sel,
   input  logic [DATA_W-1:0] wr1_data,
   input  logic              wr2_en,
   input  logic [ADDR_W-1:0] wr2_sel,
   input  logic [DATA_W-1:0] wr2_data,
   input  logic              rd1_en,
   input  logic [ADDR_W-1:0] rd1_sel,
   output logic [DATA_W-1:0] rd1_data,
   output logic              rd1_valid,
   input  logic              rd2_en,
   input  logic [ADDR_W-1:0] rd2_sel,
   output logic [DATA_W-1:0] rd2_data,
   output logic              rd2_valid
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   ptr;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic                we1, we2;
   logic                sweep_done;
   logic [DATA_W-1:0]   rd1_val, rd2_val;

   assign sweep_done = (ptr == '1);

   always_ff @(posedge clk) begin
      if (rst) state <= SWEEP;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (clear) state_nxt = SWEEP;
         SWEEP:   if (sweep_done) state_nxt = IDLE;
         default: state_nxt = SWEEP;
      endcase
   end

   // Write enables fold in the IDLE gate and the zero-register discard, so the
   // enable is checked before the select is ever compared.
   always_comb begin
      busy = (state == SWEEP);
      we1  = (state == IDLE) && wr1_en && !((ZERO_REG != 0) && (wr1_sel == '0));
      we2  = (state == IDLE) && wr2_en && !((ZERO_REG != 0) && (wr2_sel == '0));
   end

   always_ff @(posedge clk) begin
      if (rst)                ptr <= '0;
      else if (state == SWEEP) ptr <= ptr + 1'b1;
      else if (clear)         ptr <= '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == SWEEP) begin
            mem[ptr] <= RESET_VAL;
         end else begin
            if (we1) mem[wr1_sel] <= wr1_data;
            if (we2) mem[wr2_sel] <= wr2_data;
         end
      end
   end

   always_comb begin
      rd1_val = mem[rd1_sel];
      rd2_val = mem[rd2_sel];
`ifdef REGFILE_BYPASS_EN
      if (we1 && (wr1_sel == rd1_sel)) rd1_val = wr1_data;
      if (we2 && (wr2_sel == rd1_sel)) rd1_val = wr2_data;
      if (we1 && (wr1_sel == rd2_sel)) rd2_val = wr1_data;
      if (we2 && (wr2_sel == rd2_sel)) rd2_val = wr2_data;
`endif
      if ((ZERO_REG != 0) && (rd1_sel == '0)) rd1_val = '0;
      if ((ZERO_REG != 0) && (rd2_sel == '0)) rd2_val = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd1_data  <= '0;
         rd1_valid <= 1'b0;
         rd2_data  <= '0;
         rd2_valid <= 1'b0;
      end else if (state == IDLE) begin
         rd1_valid <= rd1_en;
         rd2_valid <= rd2_en;
         if (rd1_en) rd1_data <= rd1_val;
         if (rd2_en) rd2_data <= rd2_val;
      end else begin
         rd1_valid <= 1'b0;
         rd2_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_multi.sv
// Self-checking bench for regfile_multi: two instances (ZERO_REG=1 and ZERO_REG=0) on shared
// stimulus, checked every cycle against an array-level model, plus directed literal checks.
module tb_regfile_multi;

   logic        clk = 1'b0;
   logic        rst, clear;
   logic        wr1_en, wr2_en, rd1_en, rd2_en;
   logic [3:0]  wr1_sel, wr2_sel, rd1_sel, rd2_sel;
   logic [15:0] wr1_data, wr2_data;

   logic [1:0]  busy_a, rd1_v, rd2_v;
   logic [15:0] rd1_d [2];
   logic [15:0] rd2_d [2];

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   regfile_multi #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .RESET_VAL(16'h0000)) dut_z (
      .clk(clk), .rst(rst), .clear(clear), .busy(busy_a[0]),
      .wr1_en(wr1_en), .wr1_sel(wr1_sel), .wr1_data(wr1_data),
      .wr2_en(wr2_en), .wr2_sel(wr2_sel), .wr2_data(wr2_data),
      .rd1_en(rd1_en), .rd1_sel(rd1_sel), .rd1_data(rd1_d[0]), .rd1_valid(rd1_v[0]),
      .rd2_en(rd2_en), .rd2_sel(rd2_sel), .rd2_data(rd2_d[0]), .rd2_valid(rd2_v[0]));

   regfile_multi #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .RESET_VAL(16'h0000)) dut_nz (
      .clk(clk), .rst(rst), .clear(clear), .busy(busy_a[1]),
      .wr1_en(wr1_en), .wr1_sel(wr1_sel), .wr1_data(wr1_data),
      .wr2_en(wr2_en), .wr2_sel(wr2_sel), .wr2_data(wr2_data),
      .rd1_en(rd1_en), .rd1_sel(rd1_sel), .rd1_data(rd1_d[1]), .rd1_valid(rd1_v[1]),
      .rd2_en(rd2_en), .rd2_sel(rd2_sel), .rd2_data(rd2_d[1]), .rd2_valid(rd2_v[1]));

   // Model: the sweep is an edge countdown; since nothing is observable mid-sweep,
   // the whole array is zeroed when a sweep starts.
   logic [15:0] m_mem [2][16];
   logic [15:0] m_rd  [2][2];
   logic        m_val [2][2];
   int          m_left = 0;
   bit          live = 1'b0;

   always @(posedge clk) begin
      logic        en [2];
      logic [3:0]  sel [2];
      logic [15:0] v;
      en[0] = rd1_en;  sel[0] = rd1_sel;
      en[1] = rd2_en;  sel[1] = rd2_sel;
      if (rst) begin
         live = 1'b1;
         m_left = 16;
         for (int z = 0; z < 2; z++) begin
            for (int a = 0; a < 16; a++) m_mem[z][a] = 16'h0000;
            for (int p = 0; p < 2; p++) begin m_rd[z][p] = 16'h0000; m_val[z][p] = 1'b0; end
         end
      end else if (live) begin
         if (m_left > 0) begin
            m_left--;
            for (int z = 0; z < 2; z++)
               for (int p = 0; p < 2; p++) m_val[z][p] = 1'b0;
         end else begin
            for (int z = 0; z < 2; z++) begin
               for (int p = 0; p < 2; p++) begin
                  m_val[z][p] = en[p];
                  if (en[p]) begin
                     v = m_mem[z][sel[p]];
`ifdef REGFILE_BYPASS_EN
                     if (wr1_en && wr1_sel == sel[p]) v = wr1_data;
                     if (wr2_en && wr2_sel == sel[p]) v = wr2_data;
`endif
                     if (z == 0 && sel[p] == 4'd0) v = 16'h0000;
                     m_rd[z][p] = v;
                  end
               end
               if (wr1_en && !(z == 0 && wr1_sel == 4'd0)) m_mem[z][wr1_sel] = wr1_data;
               if (wr2_en && !(z == 0 && wr2_sel == 4'd0)) m_mem[z][wr2_sel] = wr2_data;
            end
            if (clear) begin
               m_left = 16;
               for (int z = 0; z < 2; z++)
                  for (int a = 0; a < 16; a++) m_mem[z][a] = 16'h0000;
            end
         end
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (live) begin
         check("busy_z", {15'd0, busy_a[0]}, {15'd0, m_left > 0});
         check("busy_nz", {15'd0, busy_a[1]}, {15'd0, m_left > 0});
         for (int z = 0; z < 2; z++) begin
            check($sformatf("rd1_valid[%0d]", z), {15'd0, rd1_v[z]}, {15'd0, m_val[z][0]});
            check($sformatf("rd2_valid[%0d]", z), {15'd0, rd2_v[z]}, {15'd0, m_val[z][1]});
            check($sformatf("rd1_data[%0d]", z), rd1_d[z], m_rd[z][0]);
            check($sformatf("rd2_data[%0d]", z), rd2_d[z], m_rd[z][1]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_in();
      clear = 1'b0;
      wr1_en = 1'b0; wr1_sel = 'x; wr1_data = 'x;
      wr2_en = 1'b0; wr2_sel = 'x; wr2_data = 'x;
      rd1_en = 1'b0; rd1_sel = 'x;
      rd2_en = 1'b0; rd2_sel = 'x;
   endtask

   task automatic wr(input int p, input logic [3:0] s, input logic [15:0] d);
      if (p == 1) begin wr1_en = 1'b1; wr1_sel = s; wr1_data = d; end
      else        begin wr2_en = 1'b1; wr2_sel = s; wr2_data = d; end
   endtask

   task automatic rd(input int p, input logic [3:0] s);
      if (p == 1) begin rd1_en = 1'b1; rd1_sel = s; end
      else        begin rd2_en = 1'b1; rd2_sel = s; end
   endtask

   // Counts observations of busy=1 starting from the current (post-edge) point.
   task automatic count_busy(output int n);
      n = 0;
      while (busy_a[0] && n < 40) begin
         n++;
         step();
         check("sweep_rd1_valid", {15'd0, rd1_v[0]}, 16'd0);
      end
   endtask

   initial begin
      int n;
      idle_in();
      rst = 1'b0;
      step();

      // Reset sweep
      rst = 1'b1; step(); step();
      check("rst_rd1_data", rd1_d[0], 16'h0000);
      check("rst_busy", {15'd0, busy_a[0]}, 16'd1);
      rst = 1'b0;
      count_busy(n);
      check("reset_busy_edges", 16'(n), 16'd16);
      for (int a = 0; a < 16; a++) begin
         idle_in(); rd(1, 4'(a)); rd(2, 4'(15 - a)); step();
         check("swept_valid", {15'd0, rd1_v[0]}, 16'd1);
         check("swept_data", rd1_d[0], 16'h0000);
         check("swept_data_nz", rd2_d[1], 16'h0000);
      end

      // Dual write / read
      idle_in(); wr(1, 4'd1, 16'hDEAD); wr(2, 4'd2, 16'hBEEF); step();
      idle_in(); rd(1, 4'd1); rd(2, 4'd2); step();
      check("dual_rd1", rd1_d[0], 16'hDEAD);
      check("dual_rd2", rd2_d[0], 16'hBEEF);
      check("dual_v2", {15'd0, rd2_v[0]}, 16'd1);
      idle_in(); step();
      check("idle_v1", {15'd0, rd1_v[0]}, 16'd0);
      check("idle_hold", rd1_d[0], 16'hDEAD);

      // Write conflict and zero register
      idle_in(); wr(1, 4'd5, 16'h1111); wr(2, 4'd5, 16'h2222); step();
      idle_in(); wr(1, 4'd0, 16'hABCD); step();
      idle_in(); rd(1, 4'd5); rd(2, 4'd0); step();
      check("conflict_wr2_wins", rd1_d[0], 16'h2222);
      check("zero_reg", rd2_d[0], 16'h0000);
      check("nonzero_reg0", rd2_d[1], 16'hABCD);

      // Read during write
      idle_in(); wr(1, 4'd3, 16'h0042); step();
      idle_in(); wr(2, 4'd3, 16'hCAFE); rd(1, 4'd3); step();
`ifdef REGFILE_BYPASS_EN
      check("rdw_same_edge", rd1_d[0], 16'hCAFE);
`else
      check("rdw_same_edge", rd1_d[0], 16'h0042);
`endif
      idle_in(); rd(1, 4'd3); step();
      check("rdw_later", rd1_d[0], 16'hCAFE);

      // Clear mid-operation
      idle_in(); wr(1, 4'd7, 16'h1234); step();
      idle_in(); clear = 1'b1; step();
      idle_in(); wr(1, 4'd8, 16'h5555); rd(1, 4'd8);
      count_busy(n);
      check("clear_busy_edges", 16'(n), 16'd16);
      idle_in(); rd(1, 4'd7); rd(2, 4'd8); step();
      check("clear_sel7", rd1_d[0], 16'h0000);
      check("clear_sel8", rd2_d[0], 16'h0000);
      check("clear_valid", {15'd0, rd2_v[0]}, 16'd1);

      // Reset mid-sweep
      idle_in(); clear = 1'b1; step();
      idle_in();
      for (int i = 0; i < 6; i++) step();
      rst = 1'b1; step();
      rst = 1'b0;
      count_busy(n);
      check("rst_midsweep_edges", 16'(n), 16'd16);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         idle_in();
         rst   = ($urandom_range(0, 249) == 0);
         clear = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 1) == 1) wr(1, 4'($urandom_range(0, 15)), 16'($urandom));
         if ($urandom_range(0, 1) == 1) wr(2, 4'($urandom_range(0, 15)), 16'($urandom));
         if ($urandom_range(0, 2) != 0) rd(1, 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 2) != 0) rd(2, wr1_en ? wr1_sel : 4'($urandom_range(0, 15)));
         step();
      end
      rst = 1'b0;
      idle_in();
      step(); step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
